wb_i2c_xfer_master: RTL and testbench
=====================================

// Module: wb_i2c_xfer_master
// PURPOSE
//  Wishbone master that turns one I2C transfer request into the CSR/DPR/CMDR register sequence for the I2CMB core.
//  Sits between the test/control stimulus (upstream) and the I2CMB Wishbone slave (downstream).
//  Handles core enable, bus select, START, address, data bytes, read ACK/NACK, STOP, and DON/NAK/AL/ERR status.
// PARAMETERS
//  LEN_W       4     request length width; 1..2**LEN_W-1 bytes per transfer (len 0 = address-only probe)
//  POLL_LIMIT  1024  max CMDR status reads per command before timeout
// PORTS
//  clk_i      in   1  clock
//  rst_i      in   1  synchronous active-high reset
//  req_valid  in   1  transfer request valid
//  req_ready  out  1  high only in IDLE; request accepted when valid&&ready
//  req_bus    in   4  I2C bus id (written to DPR before SET_I2C_BUS)
//  req_addr   in   7  7-bit slave address
//  req_rd     in   1  1 = read, 0 = write
//  req_len    in   LEN_W  byte count
//  wdat_valid in   1  write-byte stream valid
//  wdat_ready out  1  write byte consumed this cycle
//  wdat       in   8  write byte
//  rdat_valid out  1  one-cycle pulse; rdat holds a received byte
//  rdat       out  8  received byte
//  done       out  1  one-cycle pulse at end of transfer
//  status     out  3  {timeout, arb_lost, nak}, valid with done
//  cyc_o/stb_o out 1  Wishbone cycle/strobe, asserted together
//  adr_o      out  2  register select: CSR=0, DPR=1, CMDR=2
//  we_o       out  1  write enable
//  dat_o      out  8  write data
//  dat_i      in   8  read data
//  ack_i      in   1  slave acknowledge
//  irq_i      in   1  core interrupt (used only with the macro)
// BEHAVIOUR
//  Reset: all outputs 0; state = INIT; core_enabled = 0. A mid-transaction reset drops cyc_o/stb_o in the next cycle. No done pulse.
//  WB access: cyc_o/stb_o/adr_o/we_o/dat_o held stable until ack_i. Deassert in the cycle after ack_i. One access at a time.
//    Read data is sampled on ack_i.
//  FSM: INIT -> write CSR = 0xC0 (macro) or 0x80 -> IDLE.
//   IDLE -> accept request -> DPR = req_bus -> CMDR = 3'b110 -> WAIT.
//   -> CMDR = 3'b100 (START) -> WAIT.
//   -> DPR = {req_addr, req_rd} -> CMDR = 3'b001 -> WAIT.
//   Write path, per byte:
//    - wait for wdat_valid, pulse wdat_ready in the cycle the DPR write is issued;
//    - DPR = wdat -> CMDR = 3'b001 -> WAIT.
//   Read path, per byte:
//    - CMDR = 3'b010 (ACK), or 3'b011 (NACK) on the last byte -> WAIT;
//    - read DPR -> pulse rdat_valid.
//   Then CMDR = 3'b101 (STOP) -> WAIT -> DONE (done pulse, 1 cycle) -> IDLE.
//  WAIT (polling): read CMDR repeatedly.
//    - exit on bit7 DON;
//    - bit6 NAK -> status.nak = 1, skip remaining bytes, go to STOP;
//    - bit5 AL or bit4 ERR -> status.arb_lost = 1, go to DONE without STOP;
//    - POLL_LIMIT reads reached -> status.timeout = 1, go to DONE.
//  The STOP command's own NAK is ignored. Byte counter counts down from req_len; the last byte is where count == 1.
//  req_len = 0: skip the data phase and go straight to STOP (NAK still reported).
//  A new request is never accepted in the same cycle done is pulsed.
// CONFIGURATION
//  WB_XFER_IRQ_WAIT_EN defined:
//    - CSR init = 0xC0;
//    - WAIT idles with no bus traffic until irq_i = 1, then reads CMDR once (the read clears the IRQ);
//    - timeout counts cycles (POLL_LIMIT) instead of reads.
//  Undefined: CSR init = 0x80; irq_i ignored; WAIT uses polling.
// STRUCTURE
//  Shared package wb_types_pkg:
//    - register-select enum (CSR/DPR/CMDR);
//    - 3-bit command codes;
//    - CMDR status bit positions;
//    - CSR enable constants.
//  Sub-module wb_single_access: issues one Wishbone read/write.
//    - inputs: go, adr, we, wdat;
//    - outputs: busy, done pulse, rdat.
//    - The top FSM sequences calls to it.
// TESTING
//  1 Reset then idle -> first WB access is CSR write 0x80 (0xC0 with macro); req_ready = 1 afterward.
//  2 Write bus=2 addr=0x22 len=2 bytes 0xA5,0x5A; slave ACKs all. Expected:
//     - DPR writes 0x02, 0x44, 0xA5, 0x5A in order;
//     - CMDR writes 6,4,1,1,1,5;
//     - done with status = 0.
//  3 Read addr=0x22 len=3, slave returns 0x11,0x22,0x33. Expected:
//     - DPR write 0x45;
//     - CMDR 2,2,3;
//     - rdat_valid pulses 3x with those values in order.
//  4 Address NAK on write, len=4 -> no DPR data writes; STOP issued; done with status = 3'b001.
//  5 Arbitration lost (AL) during a data byte -> no STOP; status = 3'b010.
//    Slave never sets DON -> status = 3'b100 after POLL_LIMIT.
//  6 rst_i asserted mid-read while stb_o is high -> stb_o = 0 the next cycle; CSR re-init after reset is released.

Source files
------------

// File: rtl/wb_i2c_xfer_master_pkg.sv
// Shared I2CMB register map, command codes, status bit positions and FSM types
// for the Wishbone I2C transfer master.
package wb_types_pkg;

   typedef enum logic [1:0] {
      REG_CSR  = 2'd0,
      REG_DPR  = 2'd1,
      REG_CMDR = 2'd2
   } wb_reg_e;

   typedef enum logic [2:0] {
      CMD_WAIT    = 3'b000,
      CMD_WRITE   = 3'b001,
      CMD_RD_ACK  = 3'b010,
      CMD_RD_NAK  = 3'b011,
      CMD_START   = 3'b100,
      CMD_STOP    = 3'b101,
      CMD_SET_BUS = 3'b110
   } cmd_e;

   localparam int BIT_DON = 7;
   localparam int BIT_NAK = 6;
   localparam int BIT_AL  = 5;
   localparam int BIT_ERR = 4;

   localparam logic [7:0] CSR_EN     = 8'h80;
   localparam logic [7:0] CSR_EN_IRQ = 8'hC0;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_BUS_DPR,
      ST_BUS_CMD,
      ST_START_CMD,
      ST_ADDR_DPR,
      ST_ADDR_CMD,
      ST_WR_DPR,
      ST_WR_CMD,
      ST_RD_CMD,
      ST_RD_DPR,
      ST_STOP_CMD,
      ST_WAIT,
      ST_DONE
   } st_e;

   typedef struct packed {
      logic timeout;
      logic arb_lost;
      logic nak;
   } xfer_status_t;

   function automatic logic [7:0] cmd_byte(cmd_e c);
      return {5'b00000, c};
   endfunction

endpackage

// File: rtl/wb_i2c_xfer_master_if.sv
// Request/write/read streams plus the Wishbone master bus of wb_i2c_xfer_master.
// Handshakes: a request moves when req_valid && req_ready at a rising edge; a write
// byte is taken when wdat_valid && wdat_ready; rdat_valid/done are one-cycle pulses
// with no back-pressure; a Wishbone access completes on the edge where stb_o && ack_i.
interface wb_i2c_xfer_master_if #(
   parameter int LEN_W = 4
) ();
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_bus;
   logic [6:0]       req_addr;
   logic             req_rd;
   logic [LEN_W-1:0] req_len;
   logic             wdat_valid;
   logic             wdat_ready;
   logic [7:0]       wdat;
   logic             rdat_valid;
   logic [7:0]       rdat;
   logic             done;
   logic [2:0]       status;
   logic             cyc_o;
   logic             stb_o;
   logic [1:0]       adr_o;
   logic             we_o;
   logic [7:0]       dat_o;
   logic [7:0]       dat_i;
   logic             ack_i;
   logic             irq_i;

   modport master (
      input  req_valid, req_bus, req_addr, req_rd, req_len, wdat_valid, wdat,
             dat_i, ack_i, irq_i,
      output req_ready, wdat_ready, rdat_valid, rdat, done, status,
             cyc_o, stb_o, adr_o, we_o, dat_o
   );

   modport slave (
      output req_valid, req_bus, req_addr, req_rd, req_len, wdat_valid, wdat,
             dat_i, ack_i, irq_i,
      input  req_ready, wdat_ready, rdat_valid, rdat, done, status,
             cyc_o, stb_o, adr_o, we_o, dat_o
   );
endinterface

// File: rtl/wb_i2c_xfer_master_single_access.sv
// One Wishbone read or write per go pulse; bus signals held until ack_i,
// dropped the cycle after, with a done pulse and the sampled read data.
module wb_single_access
   import wb_types_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i_go,
   input  wb_reg_e    i_adr,
   input  logic       i_we,
   input  logic [7:0] i_wdat,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rdat,
   output logic       o_cyc,
   output logic       o_stb,
   output logic [1:0] o_adr,
   output logic       o_we,
   output logic [7:0] o_dat,
   input  logic [7:0] i_dat,
   input  logic       i_ack
);
   logic       r_stb;
   logic       r_done;
   logic [1:0] r_adr;
   logic       r_we;
   logic [7:0] r_dat;
   logic [7:0] r_rdat;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stb  <= 1'b0;
         r_done <= 1'b0;
         r_adr  <= 2'd0;
         r_we   <= 1'b0;
         r_dat  <= 8'h00;
         r_rdat <= 8'h00;
      end else begin
         r_done <= 1'b0;
         if (r_stb) begin
            if (i_ack) begin
               r_stb  <= 1'b0;
               r_done <= 1'b1;
               if (!r_we) r_rdat <= i_dat;
            end
         end else if (i_go) begin
            r_stb <= 1'b1;
            r_adr <= i_adr;
            r_we  <= i_we;
            r_dat <= i_wdat;
         end
      end
   end

   assign o_busy = r_stb;
   assign o_done = r_done;
   assign o_rdat = r_rdat;
   assign o_cyc  = r_stb;
   assign o_stb  = r_stb;
   assign o_adr  = r_adr;
   assign o_we   = r_we;
   assign o_dat  = r_dat;
endmodule

// File: rtl/wb_i2c_xfer_master.sv
// Sequences CSR/DPR/CMDR accesses to the I2CMB core for one I2C transfer.
// Optional WB_XFER_IRQ_WAIT_EN: CSR enables the IRQ and WAIT sleeps until irq_i.
module wb_i2c_xfer_master
   import wb_types_pkg::*;
#(
   parameter int LEN_W      = 4,
   parameter int POLL_LIMIT = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   wb_i2c_xfer_master_if.master  bus,
   output st_e                   o_dbg_state
);
   localparam int PW = $clog2(POLL_LIMIT + 1);
`ifdef WB_XFER_IRQ_WAIT_EN
   localparam logic [7:0] CSR_INIT = CSR_EN_IRQ;
`else
   localparam logic [7:0] CSR_INIT = CSR_EN;
`endif

   st_e              r_state;
   st_e              r_after;
   logic             r_pend;
   logic             r_go;
   wb_reg_e          r_acc_adr;
   logic             r_acc_we;
   logic [7:0]       r_acc_dat;
   logic [3:0]       r_bus;
   logic [6:0]       r_addr;
   logic             r_rd;
   logic [LEN_W-1:0] r_cnt;
   logic [PW-1:0]    r_poll;
   xfer_status_t     r_status;
   logic             r_core_en;
   logic             r_req_ready;
   logic             r_wdat_ready;
   logic             r_rdat_valid;
   logic [7:0]       r_rdat;
   logic             r_done;

   logic             w_busy;
   logic             w_acc_done;
   logic [7:0]       w_acc_rdat;
   logic             w_cmp;
   logic             w_iss;
   wb_reg_e          w_iss_adr;
   logic             w_iss_we;
   logic [7:0]       w_iss_dat;
   logic             w_cyc;
   logic             w_stb;
   logic [1:0]       w_adr;
   logic             w_we;
   logic [7:0]       w_dat;

   wb_single_access u_acc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_go   (r_go),
      .i_adr  (r_acc_adr),
      .i_we   (r_acc_we),
      .i_wdat (r_acc_dat),
      .o_busy (w_busy),
      .o_done (w_acc_done),
      .o_rdat (w_acc_rdat),
      .o_cyc  (w_cyc),
      .o_stb  (w_stb),
      .o_adr  (w_adr),
      .o_we   (w_we),
      .o_dat  (w_dat),
      .i_dat  (bus.dat_i),
      .i_ack  (bus.ack_i)
   );

   assign w_cmp = r_pend && w_acc_done && !w_busy;

   // Which access each state issues; the FSM only handles the completion.
   always_comb begin
      w_iss     = 1'b1;
      w_iss_adr = REG_CMDR;
      w_iss_we  = 1'b1;
      w_iss_dat = 8'h00;
      case (r_state)
         ST_INIT:      begin w_iss_adr = REG_CSR; w_iss_dat = CSR_INIT; end
         ST_BUS_DPR:   begin w_iss_adr = REG_DPR; w_iss_dat = {4'h0, r_bus}; end
         ST_BUS_CMD:   w_iss_dat = cmd_byte(CMD_SET_BUS);
         ST_START_CMD: w_iss_dat = cmd_byte(CMD_START);
         ST_ADDR_DPR:  begin w_iss_adr = REG_DPR; w_iss_dat = {r_addr, r_rd}; end
         ST_ADDR_CMD:  w_iss_dat = cmd_byte(CMD_WRITE);
         ST_WR_DPR:    begin w_iss_adr = REG_DPR; w_iss_dat = bus.wdat; w_iss = bus.wdat_valid; end
         ST_WR_CMD:    w_iss_dat = cmd_byte(CMD_WRITE);
         ST_RD_CMD:    w_iss_dat = (r_cnt == LEN_W'(1)) ? cmd_byte(CMD_RD_NAK) : cmd_byte(CMD_RD_ACK);
         ST_RD_DPR:    begin w_iss_adr = REG_DPR; w_iss_we = 1'b0; end
         ST_STOP_CMD:  w_iss_dat = cmd_byte(CMD_STOP);
`ifdef WB_XFER_IRQ_WAIT_EN
         ST_WAIT:      begin w_iss_we = 1'b0; w_iss = bus.irq_i && (r_poll != PW'(POLL_LIMIT)); end
`else
         ST_WAIT:      w_iss_we = 1'b0;
`endif
         default:      w_iss = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_INIT;
         r_after      <= ST_IDLE;
         r_pend       <= 1'b0;
         r_go         <= 1'b0;
         r_acc_adr    <= REG_CSR;
         r_acc_we     <= 1'b0;
         r_acc_dat    <= 8'h00;
         r_bus        <= 4'h0;
         r_addr       <= 7'h00;
         r_rd         <= 1'b0;
         r_cnt        <= '0;
         r_poll       <= '0;
         r_status     <= '0;
         r_core_en    <= 1'b0;
         r_req_ready  <= 1'b0;
         r_wdat_ready <= 1'b0;
         r_rdat_valid <= 1'b0;
         r_rdat       <= 8'h00;
         r_done       <= 1'b0;
      end else begin
         r_go         <= 1'b0;
         r_wdat_ready <= 1'b0;
         r_rdat_valid <= 1'b0;
         r_done       <= 1'b0;
         if (w_cmp) r_pend <= 1'b0;
         if (!r_pend && w_iss) begin
            r_go         <= 1'b1;
            r_pend       <= 1'b1;
            r_acc_adr    <= w_iss_adr;
            r_acc_we     <= w_iss_we;
            r_acc_dat    <= w_iss_dat;
            r_wdat_ready <= (r_state == ST_WR_DPR);
         end
         case (r_state)
            ST_INIT: if (w_cmp) begin
               r_core_en <= 1'b1;
               r_state   <= ST_IDLE;
            end
            ST_IDLE: begin
               if (r_req_ready && bus.req_valid) begin
                  r_req_ready <= 1'b0;
                  r_bus       <= bus.req_bus;
                  r_addr      <= bus.req_addr;
                  r_rd        <= bus.req_rd;
                  r_cnt       <= bus.req_len;
                  r_status    <= '0;
                  r_state     <= ST_BUS_DPR;
               end else begin
                  r_req_ready <= r_core_en;
               end
            end
            ST_BUS_DPR:  if (w_cmp) r_state <= ST_BUS_CMD;
            ST_BUS_CMD:  if (w_cmp) begin r_state <= ST_WAIT; r_after <= ST_START_CMD; r_poll <= '0; end
            ST_START_CMD: if (w_cmp) begin r_state <= ST_WAIT; r_after <= ST_ADDR_DPR; r_poll <= '0; end
            ST_ADDR_DPR: if (w_cmp) r_state <= ST_ADDR_CMD;
            ST_ADDR_CMD: if (w_cmp) begin
               r_state <= ST_WAIT;
               r_poll  <= '0;
               if (r_cnt == '0) r_after <= ST_STOP_CMD;
               else             r_after <= r_rd ? ST_RD_CMD : ST_WR_DPR;
            end
            ST_WR_DPR:   if (w_cmp) r_state <= ST_WR_CMD;
            ST_WR_CMD:   if (w_cmp) begin
               r_state <= ST_WAIT;
               r_poll  <= '0;
               r_after <= (r_cnt == LEN_W'(1)) ? ST_STOP_CMD : ST_WR_DPR;
               r_cnt   <= r_cnt - 1'b1;
            end
            ST_RD_CMD:   if (w_cmp) begin r_state <= ST_WAIT; r_after <= ST_RD_DPR; r_poll <= '0; end
            ST_RD_DPR:   if (w_cmp) begin
               r_rdat_valid <= 1'b1;
               r_rdat       <= w_acc_rdat;
               if (r_cnt == LEN_W'(1)) r_state <= ST_STOP_CMD;
               else begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_state <= ST_RD_CMD;
               end
            end
            // r_after == ST_DONE marks the STOP wait, whose NAK is not reported.
            ST_STOP_CMD: if (w_cmp) begin r_state <= ST_WAIT; r_after <= ST_DONE; r_poll <= '0; end
            ST_WAIT: begin
               if (w_cmp) begin
                  if (w_acc_rdat[BIT_DON]) begin
                     r_state <= r_after;
                  end else if (w_acc_rdat[BIT_NAK]) begin
                     if (r_after != ST_DONE) r_status.nak <= 1'b1;
                     r_state <= (r_after == ST_DONE) ? ST_DONE : ST_STOP_CMD;
                  end else if (w_acc_rdat[BIT_AL] || w_acc_rdat[BIT_ERR]) begin
                     r_status.arb_lost <= 1'b1;
                     r_state           <= ST_DONE;
                  end
`ifndef WB_XFER_IRQ_WAIT_EN
                  else if (r_poll == PW'(POLL_LIMIT - 1)) begin
                     r_status.timeout <= 1'b1;
                     r_state          <= ST_DONE;
                  end else begin
                     r_poll <= r_poll + 1'b1;
                  end
`endif
               end
`ifdef WB_XFER_IRQ_WAIT_EN
               else if (!r_pend && r_poll == PW'(POLL_LIMIT)) begin
                  r_status.timeout <= 1'b1;
                  r_state          <= ST_DONE;
               end else if (r_poll != PW'(POLL_LIMIT)) begin
                  r_poll <= r_poll + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.wdat_ready = r_wdat_ready;
   assign bus.rdat_valid = r_rdat_valid;
   assign bus.rdat       = r_rdat;
   assign bus.done       = r_done;
   assign bus.status     = r_status;
   assign bus.cyc_o      = w_cyc;
   assign bus.stb_o      = w_stb;
   assign bus.adr_o      = w_adr;
   assign bus.we_o       = w_we;
   assign bus.dat_o      = w_dat;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_wb_i2c_xfer_master.sv
// Directed bench for wb_i2c_xfer_master with a scripted I2CMB register responder.
// Honours WB_XFER_IRQ_WAIT_EN for the expected CSR value and irq_i level.
module tb_wb_i2c_xfer_master;
   import wb_types_pkg::*;

`ifdef WB_XFER_IRQ_WAIT_EN
   localparam logic [7:0] EXP_CSR = 8'hC0;
`else
   localparam logic [7:0] EXP_CSR = 8'h80;
`endif
   localparam int POLLS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   st_e  dbg_state;

   wb_i2c_xfer_master_if #(.LEN_W(4)) bus ();

   wb_i2c_xfer_master #(.LEN_W(4), .POLL_LIMIT(POLLS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] csr_q[$];
   logic [7:0] dpr_q[$];
   logic [7:0] cmd_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] wq[$];
   logic [7:0] rd_out_q[$];
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   logic [2:0] last_status = 3'b000;
   int         fault_idx = -1;
   logic [7:0] fault_val = 8'h00;
   int         busy_polls = 1;
   int         busy_cnt = 0;
   int         cmd_rd_cnt = 0;
   logic       stall_rd = 1'b0;

   // Register responder: acks one negedge after a strobe appears.
   always @(negedge clk) begin
      if (bus.cyc_o && bus.stb_o && !bus.ack_i && !(stall_rd && !bus.we_o)) begin
         bus.ack_i = 1'b1;
         if (bus.we_o) begin
            case (bus.adr_o)
               2'd0: csr_q.push_back(bus.dat_o);
               2'd1: dpr_q.push_back(bus.dat_o);
               default: begin cmd_q.push_back(bus.dat_o); busy_cnt = 0; cmd_rd_cnt = 0; end
            endcase
         end else if (bus.adr_o == 2'd1) begin
            bus.dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
         end else begin
            cmd_rd_cnt++;
            if (busy_cnt < busy_polls) begin
               bus.dat_i = 8'h00;
               busy_cnt++;
            end else begin
               bus.dat_i = (cmd_q.size() - 1 == fault_idx) ? fault_val : 8'h80;
            end
         end
      end else begin
         bus.ack_i = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus.wdat_valid && bus.wdat_ready && wq.size() > 0) void'(wq.pop_front());
      bus.wdat_valid = (wq.size() > 0);
      bus.wdat       = (wq.size() > 0) ? wq[0] : 8'h00;
   end

   always @(negedge clk) begin
      if (bus.rdat_valid) rd_out_q.push_back(bus.rdat);
      if (bus.done) begin
         done_cnt++;
         last_status = bus.status;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, exp[i]);
   endtask

   task automatic clear_logs();
      csr_q.delete(); dpr_q.delete(); cmd_q.delete(); rd_out_q.delete();
   endtask

   task automatic do_req(input logic [3:0] b, input logic [6:0] a, input logic rd, input logic [3:0] len);
      int n = 0;
      bus.req_bus   = b;
      bus.req_addr  = a;
      bus.req_rd    = rd;
      bus.req_len   = len;
      bus.req_valid = 1'b1;
      while (bus.req_ready !== 1'b1 && n < 500) begin @(negedge clk); #1; n++; end
      check("req_ready_seen", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin @(negedge clk); #1; n++; end
      check("done_pulse", done_cnt - start, 1);
      check("no_ready_with_done", bus.req_ready, 0);
   endtask

   initial begin
      int n;
      int done_before;
      bus.req_valid = 1'b0; bus.req_bus = 4'h0; bus.req_addr = 7'h00; bus.req_rd = 1'b0;
      bus.req_len = 4'h0; bus.wdat_valid = 1'b0; bus.wdat = 8'h00; bus.dat_i = 8'h00;
      bus.ack_i = 1'b0;
`ifdef WB_XFER_IRQ_WAIT_EN
      bus.irq_i = 1'b1;
`else
      bus.irq_i = 1'b0;
`endif

      // 1: reset values, then CSR init as first access
      repeat (3) @(negedge clk);
      #1;
      check("rst_cyc", bus.cyc_o, 0);
      check("rst_stb", bus.stb_o, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_done", bus.done, 0);
      check("rst_status", bus.status, 0);
      check("rst_state", 32'(dbg_state), 32'(ST_INIT));
      rst = 1'b0;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      check("init_csr_cnt", csr_q.size(), 1);
      check("init_csr_val", (csr_q.size() > 0) ? 32'(csr_q[0]) : 32'hDEAD, EXP_CSR);
      check("init_no_dpr", dpr_q.size(), 0);
      check("init_ready", bus.req_ready, 1);

      // 2: write two bytes
      clear_logs();
      wq.push_back(8'hA5); wq.push_back(8'h5A);
      do_req(4'd2, 7'h22, 1'b0, 4'd2);
      wait_done(2000);
      exp_q = '{8'h02, 8'h44, 8'hA5, 8'h5A};
      check_bytes("wr_dpr", dpr_q, exp_q);
      exp_q = '{8'h06, 8'h04, 8'h01, 8'h01, 8'h01, 8'h05};
      check_bytes("wr_cmdr", cmd_q, exp_q);
      check("wr_status", last_status, 3'b000);
      check("wr_bytes_taken", wq.size(), 0);

      // 3: read three bytes, ACK ACK NACK
      clear_logs();
      rd_q = '{8'h11, 8'h22, 8'h33};
      do_req(4'd1, 7'h22, 1'b1, 4'd3);
      wait_done(2000);
      exp_q = '{8'h01, 8'h45};
      check_bytes("rd_dpr", dpr_q, exp_q);
      exp_q = '{8'h06, 8'h04, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05};
      check_bytes("rd_cmdr", cmd_q, exp_q);
      exp_q = '{8'h11, 8'h22, 8'h33};
      check_bytes("rd_data", rd_out_q, exp_q);
      check("rd_status", last_status, 3'b000);

      // 4: address NAK on a four-byte write
      clear_logs();
      wq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
      fault_idx = 2; fault_val = 8'h40;
      do_req(4'd0, 7'h22, 1'b0, 4'd4);
      wait_done(2000);
      exp_q = '{8'h00, 8'h44};
      check_bytes("nak_dpr", dpr_q, exp_q);
      exp_q = '{8'h06, 8'h04, 8'h01, 8'h05};
      check_bytes("nak_cmdr", cmd_q, exp_q);
      check("nak_status", last_status, 3'b001);
      check("nak_bytes_kept", wq.size(), 4);
      wq.delete();

      // address-only probe (len 0)
      clear_logs();
      fault_idx = -1;
      do_req(4'd3, 7'h50, 1'b1, 4'd0);
      wait_done(2000);
      exp_q = '{8'h06, 8'h04, 8'h01, 8'h05};
      check_bytes("probe_cmdr", cmd_q, exp_q);
      check("probe_status", last_status, 3'b000);
      check("probe_no_rdat", rd_out_q.size(), 0);

      // 5a: arbitration lost on the first data byte
      clear_logs();
      wq = '{8'hB1, 8'hB2};
      fault_idx = 3; fault_val = 8'h20;
      do_req(4'd0, 7'h22, 1'b0, 4'd2);
      wait_done(2000);
      exp_q = '{8'h00, 8'h44, 8'hB1};
      check_bytes("al_dpr", dpr_q, exp_q);
      exp_q = '{8'h06, 8'h04, 8'h01, 8'h01};
      check_bytes("al_cmdr", cmd_q, exp_q);
      check("al_status", last_status, 3'b010);
      wq.delete();

      // 5b: START never completes
      clear_logs();
      fault_idx = 1; fault_val = 8'h00;
      do_req(4'd0, 7'h22, 1'b0, 4'd1);
      wait_done(3000);
      exp_q = '{8'h06, 8'h04};
      check_bytes("to_cmdr", cmd_q, exp_q);
      check("to_status", last_status, 3'b100);
`ifndef WB_XFER_IRQ_WAIT_EN
      check("to_poll_reads", cmd_rd_cnt, POLLS);
`endif
      fault_idx = -1;

      // 6: reset while a read strobe is held
      clear_logs();
      stall_rd = 1'b1;
      done_before = done_cnt;
      do_req(4'd0, 7'h22, 1'b1, 4'd1);
      n = 0;
      while (!(bus.stb_o === 1'b1 && bus.we_o === 1'b0) && n < 200) begin @(negedge clk); #1; n++; end
      check("mid_stb_high", bus.stb_o, 1);
      rst = 1'b1;
      @(negedge clk); #1;
      check("mid_rst_stb", bus.stb_o, 0);
      check("mid_rst_cyc", bus.cyc_o, 0);
      check("mid_rst_state", 32'(dbg_state), 32'(ST_INIT));
      repeat (2) @(negedge clk);
      #1;
      stall_rd = 1'b0;
      rd_q.delete();
      clear_logs();
      rst = 1'b0;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
      check("reinit_csr", (csr_q.size() > 0) ? 32'(csr_q[0]) : 32'hDEAD, EXP_CSR);
      check("reinit_ready", bus.req_ready, 1);
      check("reinit_no_done", done_cnt - done_before, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
